// File: rtl/squeeze_output_unit.sv
// SHAKE squeeze stage: streams rate words from the Keccak state, truncates the final word
// and requests permutations at rate-block boundaries. Optional unbounded XOF mode: SQUEEZE_XOF_EN.
module squeeze_output_unit #(
  parameter int W          = 64,
  parameter int RATE_WORDS = 17,
  parameter int LEN_WIDTH  = 32,
  localparam int SEL_W     = $clog2(RATE_WORDS),
  localparam int VB_W      = $clog2(W/8) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] out_len,
  input  logic                 block_valid,
  input  logic [W-1:0]         state_word_in,
  output logic [SEL_W-1:0]     word_sel,
  output logic                 permute_req,
  input  logic                 permute_done,
  input  logic                 stop,
  output logic [W-1:0]         data_out,
  output logic [VB_W-1:0]      valid_bytes,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 last_out,
  output logic                 busy,
  output logic                 done
);

  localparam int BYTES = W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_EMIT,
    S_PERMUTE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, rem_next;
  logic [SEL_W-1:0]     word_sel_q;
  logic                 permute_req_q;
  logic                 unbounded, stop_seen;
  logic                 full_word, xfer, at_boundary;
  logic [VB_W-1:0]      n_bytes;

`ifdef SQUEEZE_XOF_EN
  logic unbounded_q, stop_q;

  assign unbounded = unbounded_q;
  assign stop_seen = stop | stop_q;

  // A stop raised while waiting on the state is remembered until the state arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unbounded_q <= 1'b0;
      stop_q      <= 1'b0;
    end else if (state_q == S_IDLE) begin
      stop_q <= 1'b0;
      if (start) unbounded_q <= (out_len == '0);
    end else if ((state_q == S_WAIT_BLK || state_q == S_PERMUTE) && stop) begin
      stop_q <= 1'b1;
    end
  end
`else
  logic unused_stop;

  assign unbounded   = 1'b0;
  assign stop_seen   = 1'b0;
  assign unused_stop = stop;
`endif

  assign full_word   = unbounded || (remaining_q >= LEN_WIDTH'(BYTES));
  assign n_bytes     = full_word ? VB_W'(BYTES) : remaining_q[VB_W-1:0];
  assign rem_next    = (remaining_q > LEN_WIDTH'(n_bytes)) ? remaining_q - LEN_WIDTH'(n_bytes) : '0;
  assign xfer        = (state_q == S_EMIT) && ready_in;
  assign at_boundary = (word_sel_q == SEL_W'(RATE_WORDS - 1));

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SQUEEZE_XOF_EN
          state_d = S_WAIT_BLK;
`else
          state_d = (out_len != '0) ? S_WAIT_BLK : S_DONE;
`endif
        end
      end
      S_WAIT_BLK: begin
        if (block_valid) state_d = stop_seen ? S_DONE : S_EMIT;
      end
      S_EMIT: begin
        if (xfer) begin
          if (!unbounded && rem_next == '0) state_d = S_DONE;
          else if (stop_seen)               state_d = S_DONE;
          else if (at_boundary)             state_d = S_PERMUTE;
        end else if (stop_seen) begin
          state_d = S_DONE;
        end
      end
      S_PERMUTE: begin
        // The cycle that carries permute_req cannot also be its acknowledgement.
        if (permute_done && !permute_req_q) state_d = stop_seen ? S_DONE : S_EMIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      word_sel_q    <= '0;
      permute_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      permute_req_q <= (state_q == S_EMIT) && (state_d == S_PERMUTE);
      if (state_q == S_IDLE && start) begin
        remaining_q <= out_len;
        word_sel_q  <= '0;
      end else if (xfer) begin
        if (!unbounded) remaining_q <= rem_next;
        word_sel_q <= (state_d == S_PERMUTE) ? '0 : word_sel_q + SEL_W'(1);
      end
    end
  end

  // Valid bytes sit in the upper lanes; lanes below them are zeroed.
  always_comb begin
    data_out = '0;
    if (state_q == S_EMIT) begin
      for (int i = 0; i < BYTES; i++) begin
        if (i >= BYTES - int'(n_bytes)) data_out[8*i +: 8] = state_word_in[8*i +: 8];
      end
    end
  end

  assign valid_out   = (state_q == S_EMIT);
  assign valid_bytes = valid_out ? n_bytes : '0;
  assign last_out    = valid_out && !unbounded && (remaining_q <= LEN_WIDTH'(BYTES));
  assign word_sel    = word_sel_q;
  assign permute_req = permute_req_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_squeeze_output_unit.sv
// Scoreboard bench for squeeze_output_unit: a byte-stream reference model fills the expected
// queue, a monitor pops on every transfer. Define SQUEEZE_XOF_EN to exercise the XOF build.
module tb_squeeze_output_unit;

  localparam int W     = 64;
  localparam int RW    = 17;
  localparam int LW    = 32;
  localparam int SEL_W = 5;
  localparam int VB_W  = 4;
  localparam int MAXB  = 4;

  logic             clk, rst, start, block_valid, permute_done, stop, ready_in;
  logic [LW-1:0]    out_len;
  logic [W-1:0]     state_word_in, data_out;
  logic [SEL_W-1:0] word_sel;
  logic [VB_W-1:0]  valid_bytes;
  logic             permute_req, valid_out, last_out, busy, done;

  squeeze_output_unit #(.W(W), .RATE_WORDS(RW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .out_len(out_len), .block_valid(block_valid),
    .state_word_in(state_word_in), .word_sel(word_sel), .permute_req(permute_req),
    .permute_done(permute_done), .stop(stop), .data_out(data_out), .valid_bytes(valid_bytes),
    .valid_out(valid_out), .ready_in(ready_in), .last_out(last_out), .busy(busy), .done(done)
  );

  typedef struct {
    logic [63:0] data;
    int          vb;
    bit          last;
    int          sel;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] blocks [MAXB][RW];
  int          blk_idx;
  int          vectors, miscompares;
  int          cyc, last_xfer_cyc, xfer_cnt, perm_cnt, exp_words, exp_perm;
  bit          done_seen, rand_ready, expect_words;

  assign state_word_in = (blk_idx < MAXB && int'(word_sel) < RW) ? blocks[blk_idx][word_sel] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid_out"},   64'(valid_out),   64'd0);
    check({tag, "_data_out"},    data_out,         64'd0);
    check({tag, "_valid_bytes"}, 64'(valid_bytes), 64'd0);
    check({tag, "_last_out"},    64'(last_out),    64'd0);
    check({tag, "_permute_req"}, 64'(permute_req), 64'd0);
    check({tag, "_done"},        64'(done),        64'd0);
    check({tag, "_busy"},        64'(busy),        64'd0);
    check({tag, "_word_sel"},    64'(word_sel),    64'd0);
  endtask

  // Consumer: always ready, or ready about two cycles in three.
  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1 ready_in = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Permutation core stand-in: answers each request after 1..3 cycles with the next block.
  initial begin
    permute_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && permute_req) begin
        perm_cnt++;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        blk_idx++;
        permute_done = 1'b1;
        @(posedge clk);
        #1 permute_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks stall stability and done timing.
  initial begin
    exp_t        e;
    bit          stalled;
    logic [63:0] s_data;
    logic [VB_W-1:0]  s_vb;
    logic        s_last;
    logic [SEL_W-1:0] s_sel;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled && valid_out) begin
        check("stall_data", data_out, s_data);
        check("stall_valid_bytes", 64'(valid_bytes), 64'(s_vb));
        check("stall_last", 64'(last_out), 64'(s_last));
        check("stall_word_sel", 64'(word_sel), 64'(s_sel));
      end
      stalled = 1'b0;
      if (!valid_out) begin
        check("outputs_zero_when_invalid", data_out | 64'(valid_bytes) | 64'(last_out), 64'd0);
      end else if (ready_in) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 64'(valid_out), 64'd0);
        end else begin
          e = sb.pop_front();
          check("data_out", data_out, e.data);
          check("valid_bytes", 64'(valid_bytes), 64'(e.vb));
          check("last_out", 64'(last_out), 64'(e.last));
          check("word_sel", 64'(word_sel), 64'(e.sel));
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end else begin
        stalled = 1'b1;
        s_data  = data_out;
        s_vb    = valid_bytes;
        s_last  = last_out;
        s_sel   = word_sel;
      end
      if (done) begin
        done_seen = 1'b1;
        if (expect_words) check("done_latency", 64'(cyc - last_xfer_cyc), 64'd1);
      end
    end
  end

  // Reference model: the output is the first len bytes of the concatenated rate blocks,
  // cut into W/8-byte words with the valid bytes kept in the upper lanes.
  task automatic start_txn(input int len, input bit rr);
    exp_t        e;
    int          rem, i, n;
    logic [63:0] all1;
    all1 = '1;
    for (int b = 0; b < MAXB; b++)
      for (int w = 0; w < RW; w++) blocks[b][w] = {$urandom, $urandom};
    blk_idx    = 0;
    sb.delete();
    rand_ready = rr;
    xfer_cnt   = 0;
    perm_cnt   = 0;
    done_seen  = 1'b0;
    rem = len;
    i   = 0;
    while (rem > 0) begin
      n      = (rem < 8) ? rem : 8;
      e.data = blocks[i / RW][i % RW] & (all1 << (8 * (8 - n)));
      e.vb   = n;
      e.last = (rem <= 8);
      e.sel  = i % RW;
      sb.push_back(e);
      rem -= n;
      i++;
    end
    exp_words    = i;
    exp_perm     = (i > 0) ? (i - 1) / RW : 0;
    expect_words = (i > 0);
    @(posedge clk);
    #1 out_len = LW'(len);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    out_len = $urandom;
  endtask

  task automatic finish_txn();
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 block_valid = 1'b1;
    for (int t = 0; t < 3000 && !done_seen; t++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", 64'(done_seen), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    block_valid = 1'b0;
    check("words_transferred", 64'(xfer_cnt), 64'(exp_words));
    check("permute_count", 64'(perm_cnt), 64'(exp_perm));
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; block_valid = 1'b0; stop = 1'b0; out_len = '0;
    rand_ready = 1'b0; blk_idx = 0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    rst = 1'b0;

    start_txn(32, 1'b0);  finish_txn();
    start_txn(13, 1'b0);  finish_txn();
    start_txn(200, 1'b0); finish_txn();
    start_txn(64, 1'b1);  finish_txn();

`ifndef SQUEEZE_XOF_EN
    start_txn(0, 1'b0);
    @(negedge clk);
    check("len0_done", 64'(done), 64'd1);
    check("len0_no_valid", 64'(valid_out), 64'd0);
    finish_txn();
`else
    begin
      exp_t e;
      start_txn(0, 1'b0);
      for (int i = 0; i < 3 * RW; i++) begin
        e.data = blocks[i / RW][i % RW];
        e.vb   = 8;
        e.last = 1'b0;
        e.sel  = i % RW;
        sb.push_back(e);
      end
      expect_words = 1'b1;
      #1 block_valid = 1'b1;
      for (int t = 0; t < 3000 && xfer_cnt < 40; t++) begin
        @(negedge clk);
        #1;
      end
      @(posedge clk);
      #1 stop = 1'b1;
      for (int t = 0; t < 100 && !done_seen; t++) begin
        @(negedge clk);
        #1;
      end
      stop = 1'b0;
      block_valid = 1'b0;
      check("xof_done_seen", 64'(done_seen), 64'd1);
      check("xof_words", 64'(xfer_cnt), 64'd41);
      check("xof_permutes", 64'(perm_cnt), 64'd2);
      sb.delete();
      @(negedge clk);
      check("xof_idle", 64'(busy), 64'd0);
    end
`endif

    // Asynchronous reset while word 3 is on the output.
    start_txn(64, 1'b0);
    #1 block_valid = 1'b1;
    for (int t = 0; t < 200 && xfer_cnt < 3; t++) begin
      @(negedge clk);
      #1;
    end
    check("reached_word3", 64'(xfer_cnt), 64'd3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("mid_reset");
    sb.delete();
    block_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start_txn(8, 1'b0); finish_txn();

    for (int k = 0; k < 8; k++) begin
      start_txn($urandom_range(1, 300), 1'($urandom_range(0, 1)));
      finish_txn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
